uart_result_tx: RTL and testbench

UART_RESULT_TX -- requirements
Module: uart_result_tx

---
 rtl/uart_result_tx_pkg.sv | 25 ++
 rtl/uart_result_msg_rom.sv | 48 ++++
 rtl/uart_result_tx.sv | 183 ++++++++++++++++++
 tb/tb_uart_result_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_result_tx_pkg.sv
// Shared definitions for the result-message UART transmitter.
// Holds the UARTsend code values, the FSM state encoding and the message lengths.
// With UART_RESULT_TX_PARITY_EN defined, an extra PARITY state is added to the encoding.
package uart_result_tx_pkg;

  localparam logic [1:0] CODE_OFF       = 2'd0;
  localparam logic [1:0] CODE_MATCH     = 2'd1;
  localparam logic [1:0] CODE_NOT_MATCH = 2'd2;

  localparam int unsigned MATCH_LEN  = 7;  // "MATCH" CR LF
  localparam int unsigned NONE_LEN   = 6;  // "NONE" CR LF
  localparam int unsigned BYTE_IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
`ifdef UART_RESULT_TX_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/uart_result_msg_rom.sv
// Combinational message ROM: returns one ASCII character of the selected result message.
// Ports: code (result code), idx (byte index) -> chr_c (character), last_c (idx is the final byte).
module uart_result_msg_rom
  import uart_result_tx_pkg::*;
(
  input  logic [1:0]            code,
  input  logic [BYTE_IDX_W-1:0] idx,
  output logic [7:0]            chr_c,
  output logic                  last_c
);

  always_comb begin
    chr_c  = 8'h00;
    last_c = 1'b0;
    case (code)
      CODE_MATCH: begin
        last_c = (idx == BYTE_IDX_W'(MATCH_LEN - 1));
        case (idx)
          4'd0:    chr_c = 8'h4D;  // M
          4'd1:    chr_c = 8'h41;  // A
          4'd2:    chr_c = 8'h54;  // T
          4'd3:    chr_c = 8'h43;  // C
          4'd4:    chr_c = 8'h48;  // H
          4'd5:    chr_c = 8'h0D;
          4'd6:    chr_c = 8'h0A;
          default: chr_c = 8'h00;
        endcase
      end
      CODE_NOT_MATCH: begin
        last_c = (idx == BYTE_IDX_W'(NONE_LEN - 1));
        case (idx)
          4'd0:    chr_c = 8'h4E;  // N
          4'd1:    chr_c = 8'h4F;  // O
          4'd2:    chr_c = 8'h4E;  // N
          4'd3:    chr_c = 8'h45;  // E
          4'd4:    chr_c = 8'h0D;
          4'd5:    chr_c = 8'h0A;
          default: chr_c = 8'h00;
        endcase
      end
      default: begin
        chr_c  = 8'h00;
        last_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/uart_result_tx.sv
// Result-message UART transmitter: sends "MATCH\r\n" or "NONE\r\n" as 8N1 frames.
// Ports: clock, reset (async, active-low), UARTsend[1:0] (result code),
//        UARTsendComplete (message sent, held until UARTsend is OFF),
//        serialOut (TX line, idle high), txBusy (message in progress).
// Macro UART_RESULT_TX_PARITY_EN: insert an even-parity bit before the stop bit.
module uart_result_tx
  import uart_result_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] UARTsend,
  output logic       UARTsendComplete,
  output logic       serialOut,
  output logic       txBusy
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  state_t                  state, state_n;
  logic [BAUD_W-1:0]       baud_cnt, baud_n;
  logic [2:0]              bit_cnt, bit_n;
  logic [BYTE_IDX_W-1:0]   byte_idx, idx_n;
  logic [7:0]              shift, shift_n;
  logic [1:0]              code, code_n;
  logic                    serial_n, done_n, busy_n;
  logic [7:0]              chr_c;
  logic                    last_c;
  logic                    bit_end_c;
`ifdef UART_RESULT_TX_PARITY_EN
  logic                    par, par_n;
`endif

  uart_result_msg_rom u_rom (
    .code   (code),
    .idx    (byte_idx),
    .chr_c  (chr_c),
    .last_c (last_c)
  );

  // Final cycle of the current serial bit.
  assign bit_end_c = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      baud_cnt         <= '0;
      bit_cnt          <= '0;
      byte_idx         <= '0;
      shift            <= '0;
      code             <= CODE_OFF;
      serialOut        <= 1'b1;
      UARTsendComplete <= 1'b0;
      txBusy           <= 1'b0;
`ifdef UART_RESULT_TX_PARITY_EN
      par              <= 1'b0;
`endif
    end else begin
      state            <= state_n;
      baud_cnt         <= baud_n;
      bit_cnt          <= bit_n;
      byte_idx         <= idx_n;
      shift            <= shift_n;
      code             <= code_n;
      serialOut        <= serial_n;
      UARTsendComplete <= done_n;
      txBusy           <= busy_n;
`ifdef UART_RESULT_TX_PARITY_EN
      par              <= par_n;
`endif
    end
  end

  // Next-state and next-output logic; serial line value is computed one cycle ahead.
  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_cnt;
    idx_n    = byte_idx;
    shift_n  = shift;
    code_n   = code;
    serial_n = serialOut;
    done_n   = UARTsendComplete;
    busy_n   = txBusy;
`ifdef UART_RESULT_TX_PARITY_EN
    par_n    = par;
`endif

    unique case (state)
      S_IDLE: begin
        serial_n = 1'b1;
        baud_n   = '0;
        if (UARTsend == CODE_MATCH || UARTsend == CODE_NOT_MATCH) begin
          code_n   = UARTsend;
          idx_n    = '0;
          state_n  = S_START;
          serial_n = 1'b0;
          busy_n   = 1'b1;
        end
      end

      S_START: begin
        baud_n = bit_end_c ? '0 : baud_cnt + BAUD_W'(1);
        if (bit_end_c) begin
          // Character is fetched at the end of the start bit; bit 0 goes out now.
          serial_n = chr_c[0];
          shift_n  = {1'b0, chr_c[7:1]};
          bit_n    = '0;
          state_n  = S_DATA;
`ifdef UART_RESULT_TX_PARITY_EN
          par_n    = ^chr_c;
`endif
        end
      end

      S_DATA: begin
        baud_n = bit_end_c ? '0 : baud_cnt + BAUD_W'(1);
        if (bit_end_c) begin
          if (bit_cnt == 3'd7) begin
`ifdef UART_RESULT_TX_PARITY_EN
            serial_n = par;
            state_n  = S_PARITY;
`else
            serial_n = 1'b1;
            state_n  = S_STOP;
`endif
          end else begin
            serial_n = shift[0];
            shift_n  = {1'b0, shift[7:1]};
            bit_n    = bit_cnt + 3'd1;
          end
        end
      end

`ifdef UART_RESULT_TX_PARITY_EN
      S_PARITY: begin
        baud_n = bit_end_c ? '0 : baud_cnt + BAUD_W'(1);
        if (bit_end_c) begin
          serial_n = 1'b1;
          state_n  = S_STOP;
        end
      end
`endif

      S_STOP: begin
        baud_n = bit_end_c ? '0 : baud_cnt + BAUD_W'(1);
        if (bit_end_c) begin
          if (last_c) begin
            serial_n = 1'b1;
            done_n   = 1'b1;
            state_n  = S_DONE;
          end else begin
            // Next start bit follows the stop bit with no idle gap.
            serial_n = 1'b0;
            idx_n    = byte_idx + BYTE_IDX_W'(1);
            state_n  = S_START;
          end
        end
      end

      S_DONE: begin
        serial_n = 1'b1;
        baud_n   = '0;
        if (UARTsend == CODE_OFF) begin
          done_n  = 1'b0;
          busy_n  = 1'b0;
          code_n  = CODE_OFF;
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n  = S_IDLE;
        serial_n = 1'b1;
        done_n   = 1'b0;
        busy_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// Self-checking bench for uart_result_tx with CLKS_PER_BIT=4.
// Expected line waveforms are built from the message text and the framing rules.
module tb_uart_result_tx;

  localparam int unsigned CPB = 4;
`ifdef UART_RESULT_TX_PARITY_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] UARTsend = 2'd0;
  logic       UARTsendComplete;
  logic       serialOut;
  logic       txBusy;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  uart_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock            (clock),
    .reset            (reset),
    .UARTsend         (UARTsend),
    .UARTsendComplete (UARTsendComplete),
    .serialOut        (serialOut),
    .txBusy           (txBusy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Reference message: the ASCII text followed by CR LF.
  task automatic load_expected(input logic [1:0] c);
    string s;
    exp_q.delete();
    s = (c == 2'd1) ? "MATCH" : "NONE";
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Send one message and check the line waveform up to completion.
  task automatic run_msg(input logic [1:0] c, input logic [1:0] switch_to, input int switch_at);
    logic samples[$];
    int   n;
    logic busy_ok;
    logic shape_ok;
    logic eb;
    logic [7:0] b;
    logic [7:0] got;
    int   base;
    load_expected(c);
    UARTsend = c;
    step;
    vectors++;
    if (serialOut !== 1'b0 || txBusy !== 1'b1) begin
      errors++;
      $display("FAIL start_edge: serialOut=%b txBusy=%b, required 0 and 1", serialOut, txBusy);
    end
    n = 0;
    busy_ok = 1'b1;
    while (UARTsendComplete !== 1'b1 && n < 4000) begin
      samples.push_back(serialOut);
      if (txBusy !== 1'b1) busy_ok = 1'b0;
      if (n == switch_at) UARTsend = switch_to;
      step;
      n++;
    end
    vectors++;
    if (n != exp_q.size() * FB * CPB) begin
      errors++;
      $display("FAIL completion_time: %0d cycles, required %0d", n, exp_q.size() * FB * CPB);
    end
    vectors++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL busy_during_msg: txBusy dropped, required 1 throughout");
    end
    vectors++;
    if (serialOut !== 1'b1 || txBusy !== 1'b1) begin
      errors++;
      $display("FAIL done_state: serialOut=%b txBusy=%b, required 1 and 1", serialOut, txBusy);
    end
    for (int f = 0; f < exp_q.size(); f++) begin
      if ((f + 1) * FB * CPB > samples.size()) break;
      base = f * FB * CPB;
      b = exp_q[f];
      got = '0;
      shape_ok = 1'b1;
      for (int k = 0; k < FB; k++) begin
        if (k == 0) eb = 1'b0;
        else if (k <= 8) eb = b[k-1];
        else if (k == FB - 1) eb = 1'b1;
        else eb = ^b;
        for (int cc = 0; cc < CPB; cc++)
          if (samples[base + k*CPB + cc] !== eb) shape_ok = 1'b0;
        if (k >= 1 && k <= 8) got[k-1] = samples[base + k*CPB + CPB/2];
      end
      vectors++;
      if (got !== b) begin
        errors++;
        $display("FAIL byte%0d: received %02h, required %02h", f, got, b);
      end
      vectors++;
      if (!shape_ok) begin
        errors++;
        $display("FAIL frame%0d_shape: waveform differs from framed %02h", f, b);
      end
    end
  endtask

  // Hold a nonzero code in DONE, then release to OFF.
  task automatic finish_msg(input logic [1:0] hold, input int cycles);
    logic ok;
    ok = 1'b1;
    UARTsend = hold;
    repeat (cycles) begin
      step;
      if (UARTsendComplete !== 1'b1 || serialOut !== 1'b1 || txBusy !== 1'b1) ok = 1'b0;
    end
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL done_hold: complete/line/busy left 1/1/1 while code=%0d", hold);
    end
    UARTsend = 2'd0;
    step;
    vectors++;
    if (UARTsendComplete !== 1'b0 || txBusy !== 1'b0) begin
      errors++;
      $display("FAIL done_release: complete=%b txBusy=%b, required 0 and 0", UARTsendComplete, txBusy);
    end
  endtask

  task automatic test_reset;
    UARTsend = 2'd0;
    reset = 1'b0;
    repeat (3) step;
    vectors++;
    if (serialOut !== 1'b1 || UARTsendComplete !== 1'b0 || txBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: line=%b complete=%b busy=%b, required 1 0 0",
               serialOut, UARTsendComplete, txBusy);
    end
    reset = 1'b1;
    step;
  endtask

  task automatic test_idle_codes;
    for (int i = 0; i < 100; i++) begin
      UARTsend = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
      step;
      vectors++;
      if (serialOut !== 1'b1 || txBusy !== 1'b0) begin
        errors++;
        $display("FAIL idle_code%0d: line=%b busy=%b, required 1 and 0", UARTsend, serialOut, txBusy);
      end
    end
    UARTsend = 2'd0;
    step;
  endtask

  task automatic test_match;
    run_msg(2'd1, 2'd1, -1);
    finish_msg(2'd1, int'($urandom_range(1, 20)));
  endtask

  task automatic test_not_match;
    run_msg(2'd2, 2'd2, -1);
    finish_msg(2'd2, int'($urandom_range(1, 20)));
  endtask

  task automatic test_switch_mid;
    run_msg(2'd1, 2'd2, int'($urandom_range(10, 250)));
    finish_msg(2'd2, 60);
  endtask

  task automatic test_reset_mid;
    UARTsend = 2'd1;
    step;
    repeat (49) step;
    vectors++;
    if (txBusy !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_reset: txBusy=%b, required 1", txBusy);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (serialOut !== 1'b1 || UARTsendComplete !== 1'b0 || txBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: line=%b complete=%b busy=%b, required 1 0 0",
               serialOut, UARTsendComplete, txBusy);
    end
    UARTsend = 2'd2;
    repeat (3) step;
    reset = 1'b1;
    run_msg(2'd2, 2'd2, -1);
    finish_msg(2'd2, 5);
  endtask

  task automatic test_back_to_back;
    logic [1:0] c;
    logic [1:0] sw;
    int gap;
    logic ok;
    for (int m = 0; m < 4; m++) begin
      c   = 2'($urandom_range(1, 2));
      sw  = 2'($urandom_range(0, 3));
      gap = int'($urandom_range(0, 10));
      ok  = 1'b1;
      for (int g = 0; g < gap; g++) begin
        UARTsend = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
        step;
        if (serialOut !== 1'b1 || txBusy !== 1'b0) ok = 1'b0;
      end
      vectors++;
      if (!ok) begin
        errors++;
        $display("FAIL gap%0d_idle: line went low or busy during idle gap", m);
      end
      run_msg(c, sw, int'($urandom_range(0, 200)));
      finish_msg(2'($urandom_range(1, 3)), int'($urandom_range(0, 5)));
    end
  endtask

  initial begin
    test_reset;
    test_idle_codes;
    test_match;
    test_not_match;
    test_switch_mid;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
